aes_inv_cipher_top: RTL and testbench

Iterative AES-128 decryptor; the receive-side counterpart of aes_cipher_top in the same ASAP7 flow. A key-load phase expands the cipher key once into 11 stored round keys. Each decryption then runs one inverse round per clock, applying the round keys in reverse order. Port naming and handshakes mirror aes_cipher_top, so both blocks share the eqy/partition flow.

---
 rtl/aes_inv_pkg.sv | 72 +++++++
 rtl/aes_inv_if.sv | 29 ++
 rtl/aes_inv_sbox.sv | 31 +++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes_inv_cipher_top.sv | 184 ++++++++++++++++++
 tb/tb_aes_inv_cipher_top.sv | 220 ++++++++++++++++++++++
 6 files changed

// File: rtl/aes_inv_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 decryptor.
// Contents:
//   aes_block_t / aes_word_t : 128-bit block and 32-bit word types
//   aes_inv_state_e          : control FSM states
//   RCON[1:10]               : key-expansion round constants
//   xtime, gmul              : GF(2^8) arithmetic, reduction polynomial 0x11B
//   inv_shift_rows           : InvShiftRows on a block
//   inv_mix_columns          : InvMixColumns on a block
// Byte 0 of a block sits in bits [127:120]; the state is column-major, so byte 4*c+r is
// row r of column c.
package aes_inv_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic [1:0] {
    StIdle,
    StKexp,
    StReady,
    StDec
  } aes_inv_state_e;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Row r is rotated right by r columns: out[r][c] = in[r][(c - r) mod 4].
  function automatic aes_block_t inv_shift_rows(input aes_block_t s);
    aes_block_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic aes_block_t inv_mix_columns(input aes_block_t s);
    aes_block_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_if.sv
// Key/data handshake bundle between a host and aes_inv_cipher_top.
//   kld, key      : key-load strobe and 128-bit cipher key (host -> core)
//   ld, text_in   : ciphertext-load strobe and block (host -> core)
//   kdone         : round-key table valid (core -> host)
//   done          : one-cycle completion pulse (core -> host)
//   text_out      : recovered plaintext, held until the next completed block (core -> host)
// Modports: master = host side, slave = core side.
interface aes_inv_if;
  import aes_inv_pkg::*;

  logic       kld;
  aes_block_t key;
  logic       kdone;
  logic       ld;
  aes_block_t text_in;
  logic       done;
  aes_block_t text_out;

  modport master (
    output kld, key, ld, text_in,
    input  kdone, done, text_out
  );

  modport slave (
    input  kld, key, ld, text_in,
    output kdone, done, text_out
  );

endinterface

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, 8-bit combinational lookup.
//   in_byte  : input byte
//   out_byte : InvSubBytes(in_byte)
module aes_inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry i lives in bits [2047-8i -: 8]; 2047-8i == {~i, 3'b111}.
  localparam logic [2047:0] InvSboxTbl = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign out_byte = InvSboxTbl[{~in_byte, 3'b111} -: 8];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, 8-bit combinational lookup.
//   in_byte  : input byte
//   out_byte : SubBytes(in_byte)
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry i lives in bits [2047-8i -: 8]; 2047-8i == {~i, 3'b111}.
  localparam logic [2047:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SboxTbl[{~in_byte, 3'b111} -: 8];

endmodule

// File: rtl/aes_inv_cipher_top.sv
// Iterative AES-128 decryptor. A kld expands the key once into NR+1 stored round keys
// (one per clock); each ld then runs one inverse round per clock, using the round keys
// in reverse order, and pulses done 10 edges after ld is sampled.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset
//   bus       : aes_inv_if.slave (kld/key/kdone, ld/text_in/done/text_out)
//   dbg_round : (AES_INV_EQUIV_TAP_EN only) rcnt in DEC, kcnt in KEXP, 4'hF otherwise
//   dbg_state : (AES_INV_EQUIV_TAP_EN only) live state register
// Define AES_INV_EQUIV_TAP_EN to expose the equivalence-check tap ports.
module aes_inv_cipher_top
  import aes_inv_pkg::*;
#(
  parameter int unsigned NR = 10,
  parameter int unsigned NK = 4
) (
  input  logic            clk,
  input  logic            rst,
  aes_inv_if.slave        bus
`ifdef AES_INV_EQUIV_TAP_EN
  ,
  output logic [3:0]      dbg_round,
  output aes_block_t      dbg_state
`endif
);

  localparam int unsigned NumRk = NR + 1;

  aes_inv_state_e state_q, state_d;
  logic [3:0]     kcnt_q, kcnt_d;
  logic [3:0]     rcnt_q, rcnt_d;
  aes_block_t     blk_q, blk_d;
  aes_block_t     text_out_q, text_out_d;
  logic           kdone_q, kdone_d;
  logic           done_q, done_d;

  // Round-key storage is deliberately not reset; kdone_q qualifies it.
  aes_block_t rk_q [NumRk];
  aes_block_t last_rk_q;
  logic       rk_we;
  logic [3:0] rk_widx;
  aes_block_t rk_wdata;

  // Key expansion: next round key from the most recently written one.
  aes_word_t  rot_w, sub_w, temp_w, w_prev;
  aes_block_t next_rk;

  assign rot_w = {last_rk_q[23:0], last_rk_q[31:24]};

  for (genvar g = 0; g < 4; g++) begin : gen_key_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_w[31 - 8 * g -: 8]),
      .out_byte (sub_w[31 - 8 * g -: 8])
    );
  end

  assign temp_w = sub_w ^ {RCON[kcnt_q], 24'h000000};

  always_comb begin
    next_rk = '0;
    w_prev  = temp_w;
    for (int unsigned w = 0; w < NK; w++) begin
      next_rk[127 - 32 * w -: 32] = last_rk_q[127 - 32 * w -: 32] ^ w_prev;
      w_prev = next_rk[127 - 32 * w -: 32];
    end
  end

  // Inverse round datapath.
  aes_block_t sr_blk, sb_blk, ark_blk, imc_blk;

  assign sr_blk = inv_shift_rows(blk_q);

  for (genvar g = 0; g < 16; g++) begin : gen_inv_sbox
    aes_inv_sbox u_inv_sbox (
      .in_byte  (sr_blk[127 - 8 * g -: 8]),
      .out_byte (sb_blk[127 - 8 * g -: 8])
    );
  end

  assign ark_blk = sb_blk ^ rk_q[rcnt_q];
  assign imc_blk = inv_mix_columns(ark_blk);

  // Control: kld takes priority over everything, in every state.
  always_comb begin
    state_d    = state_q;
    kcnt_d     = kcnt_q;
    rcnt_d     = rcnt_q;
    blk_d      = blk_q;
    text_out_d = text_out_q;
    kdone_d    = kdone_q;
    done_d     = 1'b0;
    rk_we      = 1'b0;
    rk_widx    = kcnt_q;
    rk_wdata   = next_rk;

    if (bus.kld) begin
      state_d  = StKexp;
      kcnt_d   = 4'd1;
      rcnt_d   = 4'd0;
      kdone_d  = 1'b0;
      rk_we    = 1'b1;
      rk_widx  = 4'd0;
      rk_wdata = bus.key;
    end else begin
      unique case (state_q)
        StIdle: ;
        StKexp: begin
          rk_we  = 1'b1;
          kcnt_d = kcnt_q + 4'd1;
          if (kcnt_q == 4'(NR)) begin
            kdone_d = 1'b1;
            kcnt_d  = 4'd0;
            state_d = StReady;
          end
        end
        StReady: begin
          if (bus.ld) begin
            blk_d   = bus.text_in ^ rk_q[NR];
            rcnt_d  = 4'(NR - 1);
            state_d = StDec;
          end
        end
        StDec: begin
          if (rcnt_q == 4'd0) begin
            // Final round skips InvMixColumns.
            blk_d      = ark_blk;
            text_out_d = ark_blk;
            done_d     = 1'b1;
            state_d    = StReady;
          end else begin
            blk_d  = imc_blk;
            rcnt_d = rcnt_q - 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      kcnt_q     <= 4'd0;
      rcnt_q     <= 4'd0;
      blk_q      <= '0;
      text_out_q <= '0;
      kdone_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      kcnt_q     <= kcnt_d;
      rcnt_q     <= rcnt_d;
      blk_q      <= blk_d;
      text_out_q <= text_out_d;
      kdone_q    <= kdone_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && rk_we) begin
      rk_q[rk_widx] <= rk_wdata;
      last_rk_q     <= rk_wdata;
    end
  end

  assign bus.kdone    = kdone_q;
  assign bus.done     = done_q;
  assign bus.text_out = text_out_q;

`ifdef AES_INV_EQUIV_TAP_EN
  always_comb begin
    dbg_round = 4'hF;
    unique case (state_q)
      StDec:   dbg_round = rcnt_q;
      StKexp:  dbg_round = kcnt_q;
      default: dbg_round = 4'hF;
    endcase
  end

  assign dbg_state = blk_q;
`endif

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Scoreboard bench for aes_inv_cipher_top using FIPS-197 vectors.
module tb_aes_inv_cipher_top;
  import aes_inv_pkg::*;

  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_inv_if bus ();

  aes_inv_cipher_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] pt;
    int           at;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done cycle=%0d text_out=%h", cyc, bus.text_out);
      end else begin
        e = sb.pop_front();
        chk("plaintext", bus.text_out, e.pt);
        chk("done_cycle", 128'(cyc), 128'(e.at));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic load_key(input logic [127:0] k, output int kcyc);
    bus.key = k;
    bus.kld = 1'b1;
    step();
    kcyc    = cyc;
    bus.kld = 1'b0;
  endtask

  task automatic wait_kdone(input int kcyc);
    int n;
    n = 0;
    while (bus.kdone !== 1'b1 && n < 25) begin
      step();
      n++;
    end
    if (bus.kdone === 1'b1) begin
      chk("kdone_rise_cycle", 128'(cyc), 128'(kcyc + 10));
    end else begin
      checks++;
      failures++;
      $display("FAIL kdone_timeout actual=%b required=1", bus.kdone);
    end
  endtask

  task automatic issue(input logic [127:0] ct, input logic [127:0] pt, input bit expect_done);
    exp_t e;
    bus.text_in = ct;
    bus.ld      = 1'b1;
    step();
    bus.ld = 1'b0;
    if (expect_done) begin
      e.pt = pt;
      e.at = cyc + 10;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("outstanding_blocks", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int kc;
    int n;
    bus.kld     = 1'b0;
    bus.ld      = 1'b0;
    bus.key     = '0;
    bus.text_in = '0;

    // Reset values.
    idle(2);
    chk("reset_kdone", 128'(bus.kdone), 128'd0);
    chk("reset_done", 128'(bus.done), 128'd0);
    chk("reset_text_out", bus.text_out, 128'd0);
    rst = 1'b1;

    // ld in IDLE is ignored.
    issue(CtC1, PtC1, 1'b0);
    idle(15);
    chk("idle_ld_text_out", bus.text_out, 128'd0);

    // FIPS-197 C.1.
    load_key(KeyC1, kc);
    chk("kdone_low_after_kld", 128'(bus.kdone), 128'd0);
    wait_kdone(kc);
    issue(CtC1, PtC1, 1'b1);
    drain();

    // FIPS-197 App. B, then back-to-back ld in the done cycle.
    load_key(KeyB, kc);
    wait_kdone(kc);
    issue(CtB, PtB, 1'b1);
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("done_seen_for_b2b", 128'(bus.done), 128'd1);
    issue(CtB, PtB, 1'b1);
    drain();

    // ld during key expansion is dropped.
    load_key(KeyC1, kc);
    idle(2);
    issue(CtC1, PtC1, 1'b0);
    wait_kdone(kc);
    idle(20);
    chk("kexp_ld_text_out_held", bus.text_out, PtB);
    issue(CtC1, PtC1, 1'b1);
    drain();

    // kld at DEC cycle 5 aborts decryption.
    load_key(KeyB, kc);
    wait_kdone(kc);
    issue(CtB, PtB, 1'b0);
    idle(4);
    load_key(KeyC1, kc);
    chk("abort_kdone_low", 128'(bus.kdone), 128'd0);
    wait_kdone(kc);
    chk("abort_text_out_held", bus.text_out, PtC1);
    issue(CtC1, PtC1, 1'b1);
    drain();

    // Reset at DEC cycle 7.
    issue(CtC1, PtC1, 1'b0);
    idle(6);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_done", 128'(bus.done), 128'd0);
    chk("midrst_kdone", 128'(bus.kdone), 128'd0);
    chk("midrst_text_out", bus.text_out, 128'd0);
    issue(CtC1, PtC1, 1'b0);
    idle(20);
    chk("postrst_ld_ignored", bus.text_out, 128'd0);
    load_key(KeyC1, kc);
    wait_kdone(kc);
    issue(CtC1, PtC1, 1'b1);
    drain();

    // kld and ld together while READY: only key expansion starts.
    bus.key     = KeyB;
    bus.text_in = CtB;
    bus.kld     = 1'b1;
    bus.ld      = 1'b1;
    step();
    kc      = cyc;
    bus.kld = 1'b0;
    bus.ld  = 1'b0;
    wait_kdone(kc);
    idle(12);
    chk("kld_ld_text_out_held", bus.text_out, PtC1);
    issue(CtB, PtB, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
